// File: rtl/store_split_unit_pkg.sv
// store_split_unit_pkg: store-size encodings, sequencer states and the size decode
package store_split_unit_pkg;
  localparam logic [1:0] STORE_SIZE_B = 2'd0;
  localparam logic [1:0] STORE_SIZE_H = 2'd1;
  localparam logic [1:0] STORE_SIZE_W = 2'd2;
  localparam logic [1:0] STORE_SIZE_D = 2'd3;
  typedef enum logic [2:0] {SSU_IDLE, SSU_BEAT0, SSU_BEAT1, SSU_FIN, SSU_TRAP} ssu_state_e;
  function automatic logic [1:0] ssu_store_size(input logic [1:0] f3, input logic amo, input logic is64);
    return amo ? ((is64 && f3 == STORE_SIZE_D) ? STORE_SIZE_D : STORE_SIZE_W) : f3;
  endfunction
endpackage

// File: rtl/store_split_unit_if.sv
// store_split_unit_if: request side and memory-beat side of the store path
interface store_split_unit_if #(parameter int XLEN = 32);
  localparam int NB = XLEN / 8;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic            req_amo;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            mem_valid;
  logic            mem_ready;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [NB-1:0]   mem_wstrb;
  logic            done;
  logic            exc_misaligned;
  logic [XLEN-1:0] exc_addr;
  modport master (
    output req_valid, req_funct3, req_amo, req_addr, req_wdata, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, exc_misaligned, exc_addr
  );
  modport slave (
    input  req_valid, req_funct3, req_amo, req_addr, req_wdata, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, exc_misaligned, exc_addr
  );
endinterface

// File: rtl/store_lane_shifter.sv
// store_lane_shifter: size-masked byte strobes and data shifted into a two-beat window
module store_lane_shifter #(
  parameter int XLEN = 32
) (
  input  logic [1:0]                 size,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [XLEN-1:0]            wdata,
  output logic [2*(XLEN/8)-1:0]      strb2,
  output logic [2*XLEN-1:0]          data2
);
  localparam int NB = XLEN / 8;
  logic [NB-1:0]   bmask;
  logic [XLEN-1:0] dmask;
  // a size wider than the bus wraps to zero here, leaving an all-ones mask
  assign bmask = (NB'(1) << (4'd1 << size)) - NB'(1);
  for (genvar i = 0; i < NB; i++) begin : g_mask
    assign dmask[8*i +: 8] = {8{bmask[i]}};
  end
  assign strb2 = {{NB{1'b0}}, bmask} << off;
  assign data2 = {{XLEN{1'b0}}, wdata & dmask} << {off, 3'b000};
endmodule

// File: rtl/store_split_unit.sv
// store_split_unit: handshaked store sequencer issuing one or two aligned beats or a misalignment trap
module store_split_unit
  import store_split_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int SPLIT_MISALIGNED = 1
) (
  input logic          clk,
  input logic          resetn,
  store_split_unit_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  ssu_state_e        state_q, state_d;
  logic [1:0]        size;
  logic [OW-1:0]     off;
  logic [2*NB-1:0]   s2;
  logic [2*XLEN-1:0] d2;
  logic              accept, hs, misaligned, trap, load0, load1;
  logic              req_ready_q, req_ready_d, mem_valid_q, mem_valid_d;
  logic              done_q, done_d, exc_q, exc_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, exc_addr_q, exc_addr_d;
  logic [XLEN-1:0]   hi_data_q, hi_data_d;
  logic [NB-1:0]     mem_wstrb_q, mem_wstrb_d, hi_strb_q, hi_strb_d;

  assign size       = ssu_store_size(bus.req_funct3[1:0], bus.req_amo, XLEN == 64);
  assign off        = bus.req_addr[OW-1:0];
  assign misaligned = (bus.req_addr[2:0] & ((3'd1 << size) - 3'd1)) != 3'd0;
  assign accept     = bus.req_valid && req_ready_q;
  assign hs         = mem_valid_q && bus.mem_ready;
  // atomics are never split; doubleword stores do not exist on a 32-bit bus
  assign trap       = (misaligned && (SPLIT_MISALIGNED == 0 || bus.req_amo)) ||
                      (XLEN == 32 && bus.req_funct3[1:0] == STORE_SIZE_D);

  store_lane_shifter #(.XLEN(XLEN)) u_shift (
    .size  (size),
    .off   (off),
    .wdata (bus.req_wdata),
    .strb2 (s2),
    .data2 (d2)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= SSU_IDLE;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      hi_data_q   <= '0;
      hi_strb_q   <= '0;
      done_q      <= 1'b0;
      exc_q       <= 1'b0;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      hi_data_q   <= hi_data_d;
      hi_strb_q   <= hi_strb_d;
      done_q      <= done_d;
      exc_q       <= exc_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SSU_IDLE:  if (accept) state_d = trap ? SSU_TRAP : SSU_BEAT0;
      SSU_BEAT0: if (hs) state_d = (hi_strb_q != '0) ? SSU_BEAT1 : SSU_FIN;
      SSU_BEAT1: if (hs) state_d = SSU_FIN;
      default:   state_d = SSU_IDLE;
    endcase
  end

  assign load0 = state_q == SSU_IDLE && state_d == SSU_BEAT0;
  assign load1 = state_q == SSU_BEAT0 && state_d == SSU_BEAT1;

  // ready stays low through the done cycle so a new store starts only after it
  always_comb begin
    req_ready_d = state_d == SSU_IDLE && state_q != SSU_FIN;
    mem_valid_d = state_d == SSU_BEAT0 || state_d == SSU_BEAT1;
    done_d      = state_q == SSU_FIN;
    exc_d       = state_d == SSU_TRAP;
    exc_addr_d  = exc_d ? bus.req_addr : exc_addr_q;
    mem_addr_d  = load0 ? (bus.req_addr & ~XLEN'(NB - 1)) : load1 ? mem_addr_q + XLEN'(NB) : mem_addr_q;
    mem_wstrb_d = load0 ? s2[NB-1:0] : load1 ? hi_strb_q : mem_valid_d ? mem_wstrb_q : '0;
    mem_wdata_d = load0 ? d2[XLEN-1:0] : load1 ? hi_data_q : mem_valid_d ? mem_wdata_q : '0;
    hi_strb_d   = load0 ? s2[2*NB-1:NB] : hi_strb_q;
    hi_data_d   = load0 ? d2[2*XLEN-1:XLEN] : hi_data_q;
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wstrb      = mem_wstrb_q;
  assign bus.done           = done_q;
  assign bus.exc_misaligned = exc_q;
  assign bus.exc_addr       = exc_addr_q;
endmodule

// File: tb/tb_store_split_unit.sv
// tb_store_split_unit: three configurations (32 split, 32 trap-only, 64 split) against a byte-level model
module tb_store_split_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int          sel = 0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic        req_amo = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        mem_ready = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_addr [2];
  logic [63:0] exp_data [2];
  logic [7:0]  exp_strb [2];
  bit          exp_trap;
  int          exp_n;
  logic        obs_ready, obs_valid, obs_done, obs_exc;
  logic [63:0] obs_addr, obs_wdata, obs_exc_addr;
  logic [7:0]  obs_wstrb;

  always #5 clk = ~clk;

  store_split_unit_if #(.XLEN(32)) if_a ();
  store_split_unit_if #(.XLEN(32)) if_b ();
  store_split_unit_if #(.XLEN(64)) if_c ();

  store_split_unit #(.XLEN(32), .SPLIT_MISALIGNED(1)) u_a (.clk(clk), .resetn(resetn), .bus(if_a.slave));
  store_split_unit #(.XLEN(32), .SPLIT_MISALIGNED(0)) u_b (.clk(clk), .resetn(resetn), .bus(if_b.slave));
  store_split_unit #(.XLEN(64), .SPLIT_MISALIGNED(1)) u_c (.clk(clk), .resetn(resetn), .bus(if_c.slave));

  assign if_a.req_valid = req_valid && sel == 0;
  assign if_b.req_valid = req_valid && sel == 1;
  assign if_c.req_valid = req_valid && sel == 2;
  assign if_a.mem_ready = mem_ready && sel == 0;
  assign if_b.mem_ready = mem_ready && sel == 1;
  assign if_c.mem_ready = mem_ready && sel == 2;
  assign if_a.req_funct3 = req_funct3;
  assign if_b.req_funct3 = req_funct3;
  assign if_c.req_funct3 = req_funct3;
  assign if_a.req_amo = req_amo;
  assign if_b.req_amo = req_amo;
  assign if_c.req_amo = req_amo;
  assign if_a.req_addr = req_addr[31:0];
  assign if_b.req_addr = req_addr[31:0];
  assign if_c.req_addr = req_addr;
  assign if_a.req_wdata = req_wdata[31:0];
  assign if_b.req_wdata = req_wdata[31:0];
  assign if_c.req_wdata = req_wdata;

  assign obs_ready    = sel == 0 ? if_a.req_ready : sel == 1 ? if_b.req_ready : if_c.req_ready;
  assign obs_valid    = sel == 0 ? if_a.mem_valid : sel == 1 ? if_b.mem_valid : if_c.mem_valid;
  assign obs_done     = sel == 0 ? if_a.done : sel == 1 ? if_b.done : if_c.done;
  assign obs_exc      = sel == 0 ? if_a.exc_misaligned : sel == 1 ? if_b.exc_misaligned : if_c.exc_misaligned;
  assign obs_addr     = sel == 0 ? 64'(if_a.mem_addr) : sel == 1 ? 64'(if_b.mem_addr) : if_c.mem_addr;
  assign obs_wdata    = sel == 0 ? 64'(if_a.mem_wdata) : sel == 1 ? 64'(if_b.mem_wdata) : if_c.mem_wdata;
  assign obs_wstrb    = sel == 0 ? 8'(if_a.mem_wstrb) : sel == 1 ? 8'(if_b.mem_wstrb) : if_c.mem_wstrb;
  assign obs_exc_addr = sel == 0 ? 64'(if_a.exc_addr) : sel == 1 ? 64'(if_b.exc_addr) : if_c.exc_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // walks the store byte by byte, placing each into its beat and lane
  task automatic model(input int nb, input bit sp, input logic [2:0] f3, input bit amo,
                       input logic [63:0] addr, input logic [63:0] wd);
    int sz, pos, j, lane;
    logic [63:0] amask;
    sz = amo ? ((nb == 8 && f3[1:0] == 2'd3) ? 8 : 4) : (1 << f3[1:0]);
    exp_trap = ((addr % 64'(sz)) != 0 && (!sp || amo)) || (nb == 4 && f3[1:0] == 2'd3);
    amask = nb == 8 ? '1 : 64'hFFFF_FFFF;
    for (int b = 0; b < 2; b++) begin
      exp_strb[b] = '0;
      exp_data[b] = '0;
      exp_addr[b] = ((addr / 64'(nb)) * 64'(nb) + 64'(b * nb)) & amask;
    end
    exp_n = 1;
    if (!exp_trap) begin
      for (int i = 0; i < sz; i++) begin
        pos = int'(addr % 64'(nb)) + i;
        j = pos / nb;
        lane = pos % nb;
        exp_strb[j][lane] = 1'b1;
        exp_data[j][lane*8 +: 8] = wd[i*8 +: 8];
      end
      exp_n = exp_strb[1] != 0 ? 2 : 1;
    end
  endtask

  task automatic do_store(input int s, input logic [2:0] f3, input bit amo, input logic [63:0] addr,
                          input logic [63:0] wd, input int stall, input bit rnd);
    int nb, k, c, c_hs;
    bit got;
    nb = s == 2 ? 8 : 4;
    if (nb == 4) begin
      addr[63:32] = '0;
      wd[63:32] = '0;
    end
    model(nb, s != 1, f3, amo, addr, wd);
    @(negedge clk);
    sel = s;
    req_funct3 = f3;
    req_amo = amo;
    req_addr = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    mem_ready = 1'b0;
    #1 chk("req_ready", obs_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_trap) begin
      chk("exc_pulse", obs_exc, 1);
      chk("exc_addr", obs_exc_addr, addr);
      chk("trap_no_valid", obs_valid, 0);
      @(negedge clk);
      chk("exc_one_cycle", obs_exc, 0);
      chk("trap_no_valid2", obs_valid, 0);
      chk("ready_after_exc", obs_ready, 1);
      chk("exc_addr_held", obs_exc_addr, addr);
      return;
    end
    k = 0;
    c = 1;
    c_hs = 0;
    got = 0;
    while (c < 60) begin
      if (obs_done) begin
        got = 1;
        break;
      end
      chk("no_exc", obs_exc, 0);
      if (c == 1) chk("valid_after_accept", obs_valid, 1);
      if (obs_valid) begin
        if (k < exp_n) begin
          chk("beat_addr", obs_addr, exp_addr[k]);
          chk("beat_strb", obs_wstrb, exp_strb[k]);
          chk("beat_data", obs_wdata, exp_data[k]);
        end else chk("extra_beat", obs_valid, 0);
        mem_ready = (c > stall) && (!rnd || $urandom_range(1) == 1);
        if (mem_ready) begin
          k++;
          c_hs = c;
        end
      end else begin
        chk("idle_strb", obs_wstrb, 0);
        chk("idle_data", obs_wdata, 0);
        mem_ready = $urandom_range(1) == 1;
      end
      @(negedge clk);
      c++;
    end
    mem_ready = 1'b0;
    chk("done_seen", got, 1);
    chk("beat_count", k, exp_n);
    chk("done_after_hs", c - c_hs, 2);
    if (!rnd && stall == 0) chk("latency", c, exp_n + 2);
    chk("valid_at_done", obs_valid, 0);
    @(negedge clk);
    chk("done_one_cycle", obs_done, 0);
    chk("ready_after_done", obs_ready, 1);
  endtask

  initial begin
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_ready", obs_ready, 1);
      chk("rst_valid", obs_valid, 0);
      chk("rst_addr", obs_addr, 0);
      chk("rst_wdata", obs_wdata, 0);
      chk("rst_wstrb", obs_wstrb, 0);
      chk("rst_done", obs_done, 0);
      chk("rst_exc", obs_exc, 0);
      chk("rst_exc_addr", obs_exc_addr, 0);
    end
    @(negedge clk);
    resetn = 1'b1;
    do_store(0, 3'd2, 0, 64'h1002, 64'hAABBCCDD, 0, 0);
    do_store(0, 3'd1, 0, 64'h1001, 64'hFFFF1234, 0, 0);
    do_store(1, 3'd2, 0, 64'h2001, 64'h0BAD_F00D, 0, 0);
    do_store(0, 3'd2, 1, 64'h2002, 64'h1234_5678, 0, 0);
    do_store(0, 3'd0, 0, 64'h3003, 64'h5A, 3, 0);
    do_store(2, 3'd3, 0, 64'h4005, 64'h1122334455667788, 0, 0);
    do_store(0, 3'd3, 0, 64'h10, 64'h1, 0, 0);
    do_store(2, 3'd3, 1, 64'h4008, 64'hCAFE_F00D_1234_5678, 0, 0);
    do_store(2, 3'd2, 1, 64'h400C, 64'hDEAD_BEEF, 0, 0);
    do_store(0, 3'd2, 0, 64'hFFFF_FFFE, 64'h0102_0304, 0, 0);
    do_store(1, 3'd1, 0, 64'h2006, 64'hBEEF, 0, 0);
    // reset while beat 1 is stalled
    @(negedge clk);
    sel = 0;
    req_funct3 = 3'd2;
    req_amo = 1'b0;
    req_addr = 64'h1002;
    req_wdata = 64'hAABBCCDD;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("beat1_pending", obs_valid, 1);
    chk("beat1_addr", obs_addr, 64'h1004);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", obs_valid, 0);
    chk("async_rst_done", obs_done, 0);
    chk("async_rst_ready", obs_ready, 1);
    chk("async_rst_strb", obs_wstrb, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", obs_valid, 0);
      chk("post_rst_done", obs_done, 0);
    end
    do_store(0, 3'd2, 0, 64'h0, 64'h8765_4321, 0, 0);
    for (int i = 0; i < 150; i++)
      do_store($urandom_range(2), 3'($urandom_range(7)), $urandom_range(7) == 0,
               {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(2), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
